// File: rtl/traffic_demand_scheduler.sv
// traffic_demand_scheduler
// Demand-driven green scheduler for the blue/black/yellow intersection.
// Requests are latched per route, green is granted round-robin among routes
// with demand, emergency preemption overrides the round-robin choice, and
// every phase change passes through yellow and an all-red clearance.
// Internally routes are indexed 0=blue 1=black 2=yellow; the external
// req/pending buses carry route i on bit 2-i.
module traffic_demand_scheduler #(
   parameter int GREEN_MIN = 4,
   parameter int GREEN_MAX = 8,
   parameter int YELLOW_T  = 2,
   parameter int ALLRED_T  = 1,
   parameter int TW        = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic       emerg,
   input  logic [1:0] emerg_route,
   output logic [5:0] R,
   output logic [1:0] active_route,
   output logic [2:0] pending
);

   typedef enum logic [1:0] {
      ALLRED = 2'd0,
      GREEN  = 2'd1,
      YELLOW = 2'd2
   } state_t;

   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [TW-1:0] T_GMIN   = TW'(GREEN_MIN);
   localparam logic [TW-1:0] T_GMAX   = TW'(GREEN_MAX);
   localparam logic [TW-1:0] T_YELLOW = TW'(YELLOW_T);
   localparam logic [TW-1:0] T_ALLRED = TW'(ALLRED_T);
   localparam logic [1:0]    NO_ROUTE = 2'd3;

   state_t        state_reg, state_next;
   logic [TW-1:0] timer_reg, timer_next, timer_inc;
   logic [1:0]    cur_reg, cur_next;
   logic [1:0]    rr_reg, rr_next;
   logic [2:0]    pending_reg, pending_next;
   logic [5:0]    r_reg, r_next;
   logic [1:0]    active_reg, active_next;

   // route-indexed views of the external buses
   logic [2:0]    dem_route, req_route, dem_route_next;
   logic [2:0]    cur_oh, set_route;
   logic          emerg_valid, grant_valid, go_yellow, others_waiting, cur_req;
   logic [1:0]    grant_route, cand1, cand2, cand3;

   function automatic logic [1:0] rr_inc(input logic [1:0] r);
      return (r == 2'd2) ? 2'd0 : r + 2'd1;
   endfunction

   // bit reordering between route index and bus position, and the lamp encoding
   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_route
         localparam logic [1:0] RI = 2'(gi);
         assign dem_route[gi]           = pending_reg[2-gi];
         assign req_route[gi]           = req[2-gi];
         assign pending_next[2-gi]      = dem_route_next[gi];
         assign r_next[5-2*gi -: 2]     = (cur_next != RI)        ? 2'b00 :
                                          (state_next == GREEN)   ? 2'b10 :
                                          (state_next == YELLOW)  ? 2'b01 : 2'b00;
      end
   endgenerate

   assign timer_inc   = (&timer_reg) ? timer_reg : timer_reg + 1'b1;
   assign cur_oh      = 3'b001 << cur_reg;
   assign active_next = (state_next == ALLRED) ? NO_ROUTE : cur_next;

   // grant selection: emergency target first, else next pending route after rr
   always_comb begin
      emerg_valid = emerg && (emerg_route != NO_ROUTE);
      cand1       = rr_inc(rr_reg);
      cand2       = rr_inc(cand1);
      cand3       = rr_reg;
      grant_valid = 1'b0;
      grant_route = cand1;
      if (emerg_valid) begin
         grant_valid = 1'b1;
         grant_route = emerg_route;
      end else if (dem_route[cand1]) begin
         grant_valid = 1'b1;
         grant_route = cand1;
      end else if (dem_route[cand2]) begin
         grant_valid = 1'b1;
         grant_route = cand2;
      end else if (dem_route[cand3]) begin
         grant_valid = 1'b1;
         grant_route = cand3;
      end
   end

   // green termination: emergency elsewhere cuts green short, otherwise
   // only competing demand can end it (at max, or at min once cur is idle)
   always_comb begin
      others_waiting = |(dem_route & ~cur_oh);
      cur_req        = |(req_route & cur_oh);
      if (emerg_valid) begin
         go_yellow = (emerg_route != cur_reg);
      end else begin
         go_yellow = others_waiting &&
                     ((timer_reg >= T_GMAX) || ((timer_reg >= T_GMIN) && !cur_req));
      end
   end

   // phase sequencing and phase timer
   always_comb begin
      state_next = state_reg;
      cur_next   = cur_reg;
      rr_next    = rr_reg;
      timer_next = timer_inc;
      case (state_reg)
         ALLRED: begin
            if ((timer_reg >= T_ALLRED) && grant_valid) begin
               state_next = GREEN;
               cur_next   = grant_route;
               rr_next    = grant_route;
            end
         end
         GREEN: begin
            if (go_yellow) state_next = YELLOW;
         end
         YELLOW: begin
            if (timer_reg >= T_YELLOW) state_next = ALLRED;
         end
         default: begin
            state_next = ALLRED;
         end
      endcase
      if (state_next != state_reg) timer_next = T_ONE;
   end

   // demand latch: a green route cannot re-arm itself, and the grant clear beats a same-cycle set
   always_comb begin
      set_route      = req_route & ~((state_reg == GREEN) ? cur_oh : 3'b000);
      dem_route_next = dem_route | set_route;
      if ((state_reg == ALLRED) && (state_next == GREEN))
         dem_route_next = dem_route_next & ~(3'b001 << grant_route);
   end

   // state and registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= ALLRED;
         timer_reg   <= T_ONE;
         cur_reg     <= 2'd0;
         rr_reg      <= 2'd2;
         pending_reg <= 3'b000;
         r_reg       <= 6'b000000;
         active_reg  <= NO_ROUTE;
      end else begin
         state_reg   <= state_next;
         timer_reg   <= timer_next;
         cur_reg     <= cur_next;
         rr_reg      <= rr_next;
         pending_reg <= pending_next;
         r_reg       <= r_next;
         active_reg  <= active_next;
      end
   end

   assign R            = r_reg;
   assign active_route = active_reg;
   assign pending      = pending_reg;

endmodule

// File: tb/tb_traffic_demand_scheduler.sv
// tb_traffic_demand_scheduler
// Directed vector table, hand-written corner sequences, and a randomized run
// compared against a phase-level reference model of the scheduler.
module tb_traffic_demand_scheduler;

   localparam int GREEN_MIN = 4;
   localparam int GREEN_MAX = 8;
   localparam int YELLOW_T  = 2;
   localparam int ALLRED_T  = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] req;
   logic       emerg;
   logic [1:0] emerg_route;
   logic [5:0] R;
   logic [1:0] active_route;
   logic [2:0] pending;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   traffic_demand_scheduler #(
      .GREEN_MIN(GREEN_MIN),
      .GREEN_MAX(GREEN_MAX),
      .YELLOW_T (YELLOW_T),
      .ALLRED_T (ALLRED_T),
      .TW       (4)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .req         (req),
      .emerg       (emerg),
      .emerg_route (emerg_route),
      .R           (R),
      .active_route(active_route),
      .pending     (pending)
   );

   typedef struct {
      logic [2:0] req;
      logic       emerg;
      logic [1:0] er;
      logic [5:0] exp_r;
      logic [1:0] exp_act;
      logic [2:0] exp_pend;
   } vec_t;

   vec_t tbl[20];

   task automatic check(input string name, input logic [5:0] got, input logic [5:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b", name, got, exp);
      end
   endtask

   // drive inputs, advance one clock, land 1 time unit after the edge
   task automatic step(input logic [2:0] r, input logic e, input logic [1:0] er, input logic rst);
      req         = r;
      emerg       = e;
      emerg_route = er;
      reset       = rst;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic [5:0] xr, input logic [1:0] xa,
                             input logic [2:0] xp);
      check({tag, ".R"}, R, xr);
      check({tag, ".active"}, {4'b0, active_route}, {4'b0, xa});
      check({tag, ".pending"}, {3'b0, pending}, {3'b0, xp});
   endtask

   task automatic sx(input string tag, input logic [2:0] r, input logic e, input logic [1:0] er,
                     input logic rst, input logic [5:0] xr, input logic [1:0] xa, input logic [2:0] xp);
      step(r, e, er, rst);
      $display("%s: req=%b emerg=%b route=%0d reset=%b -> R=%b active=%0d pending=%b",
               tag, r, e, er, rst, R, active_route, pending);
      expect_out(tag, xr, xa, xp);
   endtask

   task automatic do_reset();
      step(3'b000, 1'b0, 2'd0, 1'b1);
      step(3'b000, 1'b0, 2'd0, 1'b1);
   endtask

   // ---------------- reference model (phase level, route-indexed) ----------------
   int m_phase;   // 0 all red, 1 green, 2 yellow
   int m_age;     // cycles spent in the current phase, 1 on the first
   int m_cur;
   int m_last;
   bit m_dem[3];

   task automatic model_reset();
      m_phase = 0;
      m_age   = 1;
      m_cur   = 0;
      m_last  = 2;
      for (int i = 0; i < 3; i++) m_dem[i] = 1'b0;
   endtask

   task automatic model_step(input logic [2:0] r, input logic e, input logic [1:0] er);
      bit ev;
      bit nd[3];
      bit others;
      bit found;
      int nphase;
      int g;
      ev     = e && (er != 2'd3);
      nphase = m_phase;
      g      = 0;
      found  = 1'b0;
      others = 1'b0;
      for (int i = 0; i < 3; i++)
         nd[i] = m_dem[i] | (r[2-i] && !(m_phase == 1 && m_cur == i));
      if (m_phase == 0) begin
         if (m_age >= ALLRED_T) begin
            if (ev) begin
               g     = int'(er);
               found = 1'b1;
            end else begin
               for (int k = 1; k <= 3; k++)
                  if (!found && m_dem[(m_last + k) % 3]) begin
                     g     = (m_last + k) % 3;
                     found = 1'b1;
                  end
            end
            if (found) begin
               nphase = 1;
               m_cur  = g;
               m_last = g;
               nd[g]  = 1'b0;
            end
         end
      end else if (m_phase == 1) begin
         for (int j = 0; j < 3; j++)
            if (j != m_cur && m_dem[j]) others = 1'b1;
         if (ev) begin
            if (int'(er) != m_cur) nphase = 2;
         end else if (others && (m_age >= GREEN_MAX || (m_age >= GREEN_MIN && !r[2-m_cur]))) begin
            nphase = 2;
         end
      end else if (m_age >= YELLOW_T) begin
         nphase = 0;
      end
      m_age   = (nphase != m_phase) ? 1 : m_age + 1;
      m_phase = nphase;
      m_dem   = nd;
   endtask

   function automatic logic [5:0] model_r();
      logic [5:0] v;
      v = 6'b000000;
      if (m_phase == 1) v[5-2*m_cur -: 2] = 2'b10;
      if (m_phase == 2) v[5-2*m_cur -: 2] = 2'b01;
      return v;
   endfunction

   function automatic logic [1:0] model_act();
      return (m_phase == 0) ? 2'd3 : 2'(m_cur);
   endfunction

   function automatic logic [2:0] model_pend();
      return {m_dem[0], m_dem[1], m_dem[2]};
   endfunction

   // ---------------- test sequence ----------------
   initial begin
      int emerg_left;
      logic [1:0] er_hold;
      logic [2:0] rr;
      logic       rst;

      reset       = 1'b1;
      req         = 3'b000;
      emerg       = 1'b0;
      emerg_route = 2'd0;

      // blue served, black waits through blue max green, then blue again
      tbl[0]  = '{3'b100, 1'b0, 2'd0, 6'b000000, 2'd3, 3'b100};
      tbl[1]  = '{3'b000, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b000};
      tbl[2]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b000};
      tbl[3]  = '{3'b110, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[4]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[5]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[6]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[7]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[8]  = '{3'b100, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b010};
      tbl[9]  = '{3'b100, 1'b0, 2'd0, 6'b010000, 2'd0, 3'b010};
      tbl[10] = '{3'b100, 1'b0, 2'd0, 6'b010000, 2'd0, 3'b110};
      tbl[11] = '{3'b100, 1'b0, 2'd0, 6'b000000, 2'd3, 3'b110};
      tbl[12] = '{3'b000, 1'b0, 2'd0, 6'b001000, 2'd1, 3'b100};
      tbl[13] = '{3'b000, 1'b0, 2'd0, 6'b001000, 2'd1, 3'b100};
      tbl[14] = '{3'b000, 1'b0, 2'd0, 6'b001000, 2'd1, 3'b100};
      tbl[15] = '{3'b000, 1'b0, 2'd0, 6'b001000, 2'd1, 3'b100};
      tbl[16] = '{3'b000, 1'b0, 2'd0, 6'b000100, 2'd1, 3'b100};
      tbl[17] = '{3'b000, 1'b0, 2'd0, 6'b000100, 2'd1, 3'b100};
      tbl[18] = '{3'b000, 1'b0, 2'd0, 6'b000000, 2'd3, 3'b100};
      tbl[19] = '{3'b000, 1'b0, 2'd0, 6'b100000, 2'd0, 3'b000};

      // reset state, resting on red with no demand
      do_reset();
      $display("reset: R=%b active=%0d pending=%b", R, active_route, pending);
      expect_out("reset", 6'b000000, 2'd3, 3'b000);
      for (int i = 0; i < 5; i++)
         sx("rest_red", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b000);

      // vector table
      do_reset();
      for (int i = 0; i < 20; i++) begin
         step(tbl[i].req, tbl[i].emerg, tbl[i].er, 1'b0);
         $display("vec %0d: req=%b emerg=%b route=%0d -> R=%b active=%0d pending=%b",
                  i, tbl[i].req, tbl[i].emerg, tbl[i].er, R, active_route, pending);
         expect_out($sformatf("vec%0d", i), tbl[i].exp_r, tbl[i].exp_act, tbl[i].exp_pend);
      end

      // black and yellow served after blue, no extra blue green
      do_reset();
      sx("rr", 3'b100, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b100);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b000);
      for (int i = 0; i < 5; i++)
         sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b000);
      sx("rr", 3'b011, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b011);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b010000, 2'd0, 3'b011);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b010000, 2'd0, 3'b011);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b011);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b001000, 2'd1, 3'b001);
      for (int i = 0; i < 3; i++)
         sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b001000, 2'd1, 3'b001);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000100, 2'd1, 3'b001);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000100, 2'd1, 3'b001);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b001);
      sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000010, 2'd2, 3'b000);
      for (int i = 0; i < 8; i++)
         sx("rr", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000010, 2'd2, 3'b000);

      // emergency preempt of black to yellow route, held while emerg stays
      do_reset();
      sx("emerg", 3'b010, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b010);
      sx("emerg", 3'b000, 1'b0, 2'd0, 1'b0, 6'b001000, 2'd1, 3'b000);
      sx("emerg", 3'b000, 1'b0, 2'd0, 1'b0, 6'b001000, 2'd1, 3'b000);
      sx("emerg", 3'b000, 1'b1, 2'd2, 1'b0, 6'b000100, 2'd1, 3'b000);
      sx("emerg", 3'b000, 1'b1, 2'd2, 1'b0, 6'b000100, 2'd1, 3'b000);
      sx("emerg", 3'b000, 1'b1, 2'd2, 1'b0, 6'b000000, 2'd3, 3'b000);
      sx("emerg", 3'b000, 1'b1, 2'd2, 1'b0, 6'b000010, 2'd2, 3'b000);
      sx("emerg", 3'b110, 1'b1, 2'd2, 1'b0, 6'b000010, 2'd2, 3'b110);
      for (int i = 0; i < 11; i++)
         sx("emerg", 3'b000, 1'b1, 2'd2, 1'b0, 6'b000010, 2'd2, 3'b110);
      sx("emerg_drop", 3'b000, 1'b0, 2'd0, 1'b0, 6'b000001, 2'd2, 3'b110);

      // clear beats set on grant; reset in the middle of yellow
      do_reset();
      sx("yrst", 3'b100, 1'b0, 2'd0, 1'b0, 6'b000000, 2'd3, 3'b100);
      sx("yrst", 3'b100, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b000);
      sx("yrst", 3'b011, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b011);
      sx("yrst", 3'b000, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b011);
      sx("yrst", 3'b000, 1'b0, 2'd0, 1'b0, 6'b100000, 2'd0, 3'b011);
      sx("yrst", 3'b000, 1'b0, 2'd0, 1'b0, 6'b010000, 2'd0, 3'b011);
      sx("yrst", 3'b100, 1'b0, 2'd0, 1'b0, 6'b010000, 2'd0, 3'b111);
      sx("yrst", 3'b000, 1'b0, 2'd0, 1'b1, 6'b000000, 2'd3, 3'b000);

      // randomized run against the reference model
      do_reset();
      model_reset();
      emerg_left = 0;
      er_hold    = 2'd0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if (emerg_left == 0 && $urandom_range(0, 59) == 0) begin
            emerg_left = $urandom_range(3, 20);
            er_hold    = 2'($urandom_range(0, 3));
         end
         for (int b = 0; b < 3; b++) rr[b] = ($urandom_range(0, 5) == 0);
         rst = ($urandom_range(0, 399) == 0);
         step(rr, emerg_left > 0, er_hold, rst);
         if (rst) model_reset();
         else     model_step(rr, emerg_left > 0, er_hold);
         if (emerg_left > 0) emerg_left--;
         check("rand.R", R, model_r());
         check("rand.active", {4'b0, active_route}, {4'b0, model_act()});
         check("rand.pending", {3'b0, pending}, {3'b0, model_pend()});
         if ((cyc % 250) == 249)
            $display("random: cycles up to %0d, R=%b active=%0d pending=%b, failures so far %0d",
                     cyc, R, active_route, pending, n_fail);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
